phase_encoder: RTL and testbench
================================

Name: phase_encoder

Overview:
Inverse of the phase decoder. Converts packed 2-bit Gray phase codes from the pulse-programme datapath back into 5-bit decimal phase words (0/9/18/27 = 0°/90°/180°/270°) for the receiver/host phase record. It applies a per-scan quadrature phase-cycle rotation driven by an internal scan counter. A registered valid/ready output stage sits between the sequencer and the acquisition/readout logic.

Parameters:
N_phases, 1, number of packed phase lanes; input is 2*N_phases bits, output is 5*N_phases bits.
CYCLE_LEN, 4, number of scans in the phase cycle (1..4); the cycle index wraps at CYCLE_LEN-1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
phase_binary  input  2*N_phases  packed Gray phase codes, lane i at [2*i-1 -: 2] (i = 1..N_phases)
in_valid  input  1  phase_binary is valid this cycle
in_ready  output  1  block can accept input this cycle
scan_done  input  1  single-cycle pulse; advances the phase-cycle index
cycle_clear  input  1  single-cycle pulse; returns the cycle index to 0
phase_decimal  output  5*N_phases  packed decimal phase words, lane i at [5*i-1 -: 5]
out_valid  output  1  phase_decimal holds an unconsumed result
out_ready  input  1  downstream accepts phase_decimal this cycle
cycle_index  output  2  current phase-cycle index (0..CYCLE_LEN-1)

Behaviour:
- Reset (rst sampled high at a clk edge): phase_decimal = 0, out_valid = 0, cycle_index = 0. in_ready is combinational and therefore 1 after reset.
- Gray to quadrant q, per lane: 2'b11 -> 0, 2'b10 -> 1, 2'b00 -> 2, 2'b01 -> 3. All four codes are legal; there is no error path.
- Rotation: q_rot = (q + cycle_index) mod 4, computed as 2-bit wrap-around addition. Output word = 9*q_rot, giving 5'd0, 5'd9, 5'd18 or 5'd27. Upper word values are never produced.
- The same cycle_index applies to all lanes of one transfer.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready. On an accept, phase_decimal and out_valid=1 are registered at that edge, so latency is 1 clk.
  - Output holds when out_valid && !out_ready: phase_decimal stays stable and out_valid stays high.
  - Drain occurs when out_valid && out_ready && !(in_valid): out_valid -> 0 next edge and phase_decimal holds its last value.
  - Simultaneous drain and accept means back-to-back operation at full throughput (one word per clk).
- Cycle index state machine, with states IDX0..IDX(CYCLE_LEN-1):
  - cycle_clear -> IDX0. It has priority over scan_done in the same cycle.
  - scan_done alone -> index+1, wrapping from CYCLE_LEN-1 to 0.
  - CYCLE_LEN=1: index stays at 0 permanently.
  - Accept in the same cycle as scan_done/cycle_clear: the word uses the pre-update index. The new index applies from the next accepted input.
- Reset mid-operation: a pending output is discarded (out_valid -> 0) and the index returns to 0 at the reset edge. in_valid and scan_done are ignored while rst is high.
- in_valid, scan_done and cycle_clear may arrive while out_valid && !out_ready. scan_done and cycle_clear still act. in_valid is simply not accepted; the source must hold it.

Optional Feature:
PHASE_CYCLE_EN:
- Defined: rotation and scan counter operate as described above.
- Undefined: no rotation logic and no counter. cycle_index is tied to 0, scan_done and cycle_clear are ignored, and the output is a pure registered Gray-to-decimal encoder with the same handshake and 1-cycle latency.

Test Plan:
- Reset, then N_phases=1, PHASE_CYCLE_EN defined, index 0: drive codes 11, 10, 00, 01 back to back with out_ready=1 -> outputs 0, 9, 18, 27 on consecutive cycles, each 1 clk after accept, with out_valid continuous.
- Round trip: decimal {0,9,18,27} -> phase decoder -> this block, index 0 -> identical decimal returned for every lane with N_phases=4 (packed input 20'h0_6C_1B style vector of 0/9/18/27 per lane).
- Rotation: pulse scan_done twice (index=2), then input 11 -> 18; input 01 -> 9 (3+2 wraps to 1). With CYCLE_LEN=3, a third scan_done -> index 0.
- Backpressure: out_ready=0 with in_valid=1 for 3 cycles -> in_ready=0, first word held stable, no second accept. Raising out_ready -> second word appears on the next edge.
- Collisions: scan_done and cycle_clear in the same cycle -> index 0. Accept coincident with scan_done at index 1 and input 11 -> output 9, index 2 afterwards.
- Reset mid-transfer: out_valid=1 with out_ready=0, assert rst for 1 clk -> out_valid=0, phase_decimal=0, cycle_index=0, in_ready=1.

Source files
------------

// File: rtl/phase_encoder.sv
// rtl/phase_encoder.sv - Gray phase codes to decimal phase words with scan phase-cycle rotation
// Rotation and the scan counter exist only when PHASE_CYCLE_EN is defined.
module phase_encoder #(
    parameter int N_phases  = 1,
    parameter int CYCLE_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*N_phases-1:0]   phase_binary,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    scan_done,
    input  logic                    cycle_clear,
    output logic [5*N_phases-1:0]   phase_decimal,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              cycle_index
);

    logic                  accept;
    logic [1:0]            rot_idx;
    logic [5*N_phases-1:0] next_decimal;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef PHASE_CYCLE_EN
    typedef enum logic [1:0] {IDX0, IDX1, IDX2, IDX3} idx_state_t;

    localparam logic [1:0] LAST_IDX = 2'(CYCLE_LEN - 1);

    idx_state_t idx_state;

    // Clear wins over advance; with CYCLE_LEN=1 LAST_IDX is 0 so the index never leaves IDX0.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_state <= IDX0;
        end else if (cycle_clear) begin
            idx_state <= IDX0;
        end else if (scan_done) begin
            if (idx_state == LAST_IDX)
                idx_state <= IDX0;
            else
                idx_state <= idx_state_t'(idx_state + 2'd1);
        end
    end

    assign cycle_index = idx_state;
    assign rot_idx     = idx_state;
`else
    logic unused_cycle_inputs;
    assign unused_cycle_inputs = scan_done ^ cycle_clear;
    assign cycle_index         = 2'b00;
    assign rot_idx             = 2'b00;
`endif

    // Gray 11/10/00/01 -> quadrant 0/1/2/3, then 9*q built as 8*q + q.
    for (genvar i = 0; i < N_phases; i++) begin : g_lane
        logic [1:0] gray;
        logic [1:0] quad;
        logic [1:0] quad_rot;

        assign gray     = phase_binary[2*i+1 -: 2];
        assign quad     = {~gray[1], gray[1] ^ gray[0]};
        assign quad_rot = quad + rot_idx;
        assign next_decimal[5*i+4 -: 5] = {quad_rot, 3'b000} + {3'b000, quad_rot};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_decimal <= '0;
            out_valid     <= 1'b0;
        end else if (accept) begin
            phase_decimal <= next_decimal;
            out_valid     <= 1'b1;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_phase_encoder.sv
// tb/tb_phase_encoder.sv - directed self-checking bench for phase_encoder
// Expected rotation results depend on whether PHASE_CYCLE_EN is defined.
module tb_phase_encoder;

`ifdef PHASE_CYCLE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic [7:0]  pb;
    logic        iv, ir, sd, cc, ov, ordy;
    logic [19:0] dec;
    logic [1:0]  ci;

    logic [1:0]  pb2;
    logic        iv2, ir2, sd2, cc2, ov2, ordy2;
    logic [4:0]  dec2;
    logic [1:0]  ci2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    phase_encoder #(.N_phases(4), .CYCLE_LEN(4)) dut (
        .clk(clk), .rst(rst), .phase_binary(pb), .in_valid(iv), .in_ready(ir),
        .scan_done(sd), .cycle_clear(cc), .phase_decimal(dec), .out_valid(ov),
        .out_ready(ordy), .cycle_index(ci)
    );

    phase_encoder #(.N_phases(1), .CYCLE_LEN(3)) dut3 (
        .clk(clk), .rst(rst), .phase_binary(pb2), .in_valid(iv2), .in_ready(ir2),
        .scan_done(sd2), .cycle_clear(cc2), .phase_decimal(dec2), .out_valid(ov2),
        .out_ready(ordy2), .cycle_index(ci2)
    );

    task automatic test_reset;
        rst = 1'b1; ordy = 1'b0; ordy2 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (ov !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b expected 0", ov); end
        tests++; if (dec !== 20'd0) begin fails++; $display("FAIL reset_decimal: got %h expected 0", dec); end
        tests++; if (ci !== 2'd0) begin fails++; $display("FAIL reset_cycle_index: got %0d expected 0", ci); end
        tests++; if (ir !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b expected 1", ir); end
        tests++; if (ov2 !== 1'b0 || ci2 !== 2'd0 || ir2 !== 1'b1) begin
            fails++; $display("FAIL reset_dut3: got ov=%0b ci=%0d ir=%0b expected 0 0 1", ov2, ci2, ir2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [1:0] codes [4] = '{2'b11, 2'b10, 2'b00, 2'b01};
        logic [4:0] exp   [4] = '{5'd0, 5'd9, 5'd18, 5'd27};
        ordy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pb = {6'b111111, codes[k]}; iv = 1'b1;
            @(negedge clk);
            tests++; if (ov !== 1'b1 || dec[4:0] !== exp[k]) begin
                fails++; $display("FAIL b2b_word%0d: got ov=%0b dec=%0d expected ov=1 dec=%0d", k, ov, dec[4:0], exp[k]);
            end
        end
        iv = 1'b0;
        @(negedge clk);
        tests++; if (ov !== 1'b0 || dec[4:0] !== 5'd27) begin
            fails++; $display("FAIL b2b_drain: got ov=%0b dec=%0d expected ov=0 dec=27", ov, dec[4:0]);
        end
    endtask

    task automatic test_round_trip;
        ordy = 1'b1;
        pb = 8'h4B; iv = 1'b1;
        @(negedge clk);
        pb = 8'h36;
        tests++; if (dec !== {5'd27, 5'd18, 5'd9, 5'd0}) begin
            fails++; $display("FAIL round_trip_a: got %h expected %h", dec, {5'd27, 5'd18, 5'd9, 5'd0});
        end
        @(negedge clk);
        iv = 1'b0;
        tests++; if (dec !== {5'd18, 5'd0, 5'd27, 5'd9}) begin
            fails++; $display("FAIL round_trip_b: got %h expected %h", dec, {5'd18, 5'd0, 5'd27, 5'd9});
        end
        @(negedge clk);
    endtask

    task automatic test_rotation;
        ordy = 1'b1;
        repeat (2) begin
            sd = 1'b1; @(negedge clk); sd = 1'b0; @(negedge clk);
        end
        tests++; if (ci !== (ROT ? 2'd2 : 2'd0)) begin
            fails++; $display("FAIL rot_index: got %0d expected %0d", ci, ROT ? 2 : 0);
        end
        pb = 8'hFF; iv = 1'b1;
        @(negedge clk);
        pb = 8'hFD;
        tests++; if (dec !== (ROT ? {4{5'd18}} : 20'd0)) begin
            fails++; $display("FAIL rot_code11: got %h expected %h", dec, ROT ? {4{5'd18}} : 20'd0);
        end
        @(negedge clk);
        iv = 1'b0;
        tests++; if (dec[4:0] !== (ROT ? 5'd9 : 5'd27)) begin
            fails++; $display("FAIL rot_code01_wrap: got %0d expected %0d", dec[4:0], ROT ? 9 : 27);
        end
        @(negedge clk);
    endtask

    task automatic test_cycle_len3;
        logic [1:0] exp_idx [3] = '{2'd1, 2'd2, 2'd0};
        ordy2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sd2 = 1'b1; @(negedge clk); sd2 = 1'b0;
            tests++; if (ci2 !== (ROT ? exp_idx[k] : 2'd0)) begin
                fails++; $display("FAIL len3_index%0d: got %0d expected %0d", k, ci2, ROT ? exp_idx[k] : 2'd0);
            end
        end
        repeat (2) begin
            sd2 = 1'b1; @(negedge clk); sd2 = 1'b0; @(negedge clk);
        end
        pb2 = 2'b11; iv2 = 1'b1;
        @(negedge clk);
        iv2 = 1'b0;
        tests++; if (ov2 !== 1'b1 || dec2 !== (ROT ? 5'd18 : 5'd0)) begin
            fails++; $display("FAIL len3_word: got ov=%0b dec=%0d expected ov=1 dec=%0d", ov2, dec2, ROT ? 18 : 0);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        cc = 1'b1; @(negedge clk); cc = 1'b0;
        ordy = 1'b0; pb = 8'hFE; iv = 1'b1;
        @(negedge clk);
        pb = 8'hFC;
        tests++; if (ov !== 1'b1 || dec[4:0] !== 5'd9) begin
            fails++; $display("FAIL bp_first: got ov=%0b dec=%0d expected ov=1 dec=9", ov, dec[4:0]);
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (ir !== 1'b0 || ov !== 1'b1 || dec[4:0] !== 5'd9) begin
                fails++; $display("FAIL bp_hold%0d: got ir=%0b ov=%0b dec=%0d expected ir=0 ov=1 dec=9", k, ir, ov, dec[4:0]);
            end
            @(negedge clk);
        end
        ordy = 1'b1;
        #1;
        tests++; if (ir !== 1'b1) begin fails++; $display("FAIL bp_ready_release: got %0b expected 1", ir); end
        @(negedge clk);
        iv = 1'b0;
        tests++; if (ov !== 1'b1 || dec[4:0] !== 5'd18) begin
            fails++; $display("FAIL bp_second: got ov=%0b dec=%0d expected ov=1 dec=18", ov, dec[4:0]);
        end
        @(negedge clk);
        tests++; if (ov !== 1'b0 || dec[4:0] !== 5'd18) begin
            fails++; $display("FAIL bp_drain: got ov=%0b dec=%0d expected ov=0 dec=18", ov, dec[4:0]);
        end
    endtask

    task automatic test_collisions;
        ordy = 1'b1;
        sd = 1'b1; @(negedge clk); sd = 1'b0;
        tests++; if (ci !== (ROT ? 2'd1 : 2'd0)) begin
            fails++; $display("FAIL col_advance: got %0d expected %0d", ci, ROT ? 1 : 0);
        end
        sd = 1'b1; cc = 1'b1; @(negedge clk); sd = 1'b0; cc = 1'b0;
        tests++; if (ci !== 2'd0) begin fails++; $display("FAIL col_clear_priority: got %0d expected 0", ci); end
        sd = 1'b1; @(negedge clk);
        pb = 8'hFF; iv = 1'b1;
        @(negedge clk);
        sd = 1'b0; iv = 1'b0;
        tests++; if (dec[4:0] !== (ROT ? 5'd9 : 5'd0)) begin
            fails++; $display("FAIL col_pre_update_word: got %0d expected %0d", dec[4:0], ROT ? 9 : 0);
        end
        tests++; if (ci !== (ROT ? 2'd2 : 2'd0)) begin
            fails++; $display("FAIL col_post_index: got %0d expected %0d", ci, ROT ? 2 : 0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        ordy = 1'b0; pb = 8'hFD; iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        tests++; if (ov !== 1'b1 || dec[4:0] !== (ROT ? 5'd9 : 5'd27)) begin
            fails++; $display("FAIL rm_pending: got ov=%0b dec=%0d expected ov=1 dec=%0d", ov, dec[4:0], ROT ? 9 : 27);
        end
        rst = 1'b1; iv = 1'b1; sd = 1'b1;
        @(negedge clk);
        rst = 1'b0; iv = 1'b0; sd = 1'b0;
        #1;
        tests++; if (ov !== 1'b0 || dec !== 20'd0) begin
            fails++; $display("FAIL rm_output: got ov=%0b dec=%h expected ov=0 dec=0", ov, dec);
        end
        tests++; if (ci !== 2'd0 || ir !== 1'b1) begin
            fails++; $display("FAIL rm_index_ready: got ci=%0d ir=%0b expected ci=0 ir=1", ci, ir);
        end
        @(negedge clk);
        tests++; if (ov !== 1'b0) begin fails++; $display("FAIL rm_no_accept: got %0b expected 0", ov); end
    endtask

    initial begin
        pb = 8'hFF; iv = 1'b0; sd = 1'b0; cc = 1'b0; ordy = 1'b0;
        pb2 = 2'b11; iv2 = 1'b0; sd2 = 1'b0; cc2 = 1'b0; ordy2 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        test_reset;
        test_back_to_back;
        test_round_trip;
        test_rotation;
        test_cycle_len3;
        test_backpressure;
        test_collisions;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
